// File: rtl/slurm32_cpu_instruction_cache.sv
// Direct-mapped instruction cache for the SLURM32 fetch port.
// One-cycle hit latency; a miss fills one line with a fixed-length burst from the arbiter.
module slurm32_cpu_instruction_cache #(
  parameter int unsigned BITS         = 32,
  parameter int unsigned ADDRESS_BITS = 32,
  parameter int unsigned CACHE_LINES  = 64,
  parameter int unsigned LINE_WORDS   = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    instruction_request,
  input  logic [ADDRESS_BITS-1:0] instruction_address,
  output logic [BITS-1:0]         instruction_data,
  output logic                    instruction_valid,
  input  logic                    cache_flush,
  output logic                    cache_busy,
  output logic                    mem_request,
  output logic [ADDRESS_BITS-1:0] mem_address,
  input  logic                    mem_grant,
  input  logic [BITS-1:0]         mem_data,
  input  logic                    mem_data_valid
);

  localparam int unsigned OFFSET_BITS = $clog2(LINE_WORDS);
  localparam int unsigned INDEX_BITS  = $clog2(CACHE_LINES);
  localparam int unsigned OFFSET_LSB  = 2;
  localparam int unsigned INDEX_LSB   = OFFSET_LSB + OFFSET_BITS;
  localparam int unsigned TAG_LSB     = INDEX_LSB + INDEX_BITS;
  localparam int unsigned TAG_BITS    = ADDRESS_BITS - TAG_LSB;
  localparam int unsigned DATA_WORDS  = CACHE_LINES * LINE_WORDS;
  localparam logic [OFFSET_BITS-1:0] LAST_BEAT = OFFSET_BITS'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL_REQ,
    ST_FILL_DATA,
    ST_FILL_DONE
  } state_t;

  state_t                  r_state;
  logic                    r_mem_request;
  logic                    r_cache_busy;
  logic [ADDRESS_BITS-1:0] r_mem_address;
  logic [TAG_BITS-1:0]     r_fill_tag;
  logic [INDEX_BITS-1:0]   r_fill_index;
  logic [OFFSET_BITS-1:0]  r_beat;
  logic                    r_flush_pending;
  logic [CACHE_LINES-1:0]  r_valid;

  logic                    r_req;
  logic [TAG_BITS-1:0]     r_tag;
  logic [INDEX_BITS-1:0]   r_index;
  logic [BITS-1:0]         r_ram_q;
  logic [TAG_BITS-1:0]     r_tag_q;
  logic [BITS-1:0]         r_data_hold;

  logic [BITS-1:0]         r_data_ram [DATA_WORDS];
  logic [TAG_BITS-1:0]     r_tag_ram  [CACHE_LINES];

  logic [TAG_BITS-1:0]     w_req_tag;
  logic [INDEX_BITS-1:0]   w_req_index;
  logic [OFFSET_BITS-1:0]  w_req_offset;
  logic                    w_hit;
  logic                    w_miss;
  logic                    w_lookup_en;
  logic                    w_beat_we;
  logic                    w_tag_we;
  logic                    w_unused_addr_lsb;

  assign w_req_tag         = instruction_address[ADDRESS_BITS-1:TAG_LSB];
  assign w_req_index       = instruction_address[TAG_LSB-1:INDEX_LSB];
  assign w_req_offset      = instruction_address[INDEX_LSB-1:OFFSET_LSB];
  assign w_unused_addr_lsb = ^instruction_address[OFFSET_LSB-1:0];

  assign w_hit  = r_req && r_valid[r_index] && (r_tag_q == r_tag);
  assign w_miss = r_req && !w_hit;

  // A pending miss blocks new lookups unless a flush cancels the fill at the same edge.
  assign w_lookup_en = instruction_request && (r_state == ST_IDLE) && !(w_miss && !cache_flush);

  assign w_beat_we = (r_state == ST_FILL_DATA) && mem_data_valid;
  assign w_tag_we  = w_beat_we && (r_beat == LAST_BEAT);

  assign instruction_valid = w_hit;
  assign instruction_data  = w_hit ? r_ram_q : r_data_hold;
  assign mem_request       = r_mem_request;
  assign mem_address       = r_mem_address;
  assign cache_busy        = r_cache_busy;

  // Registered lookup and held output word.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_req       <= 1'b0;
      r_tag       <= '0;
      r_index     <= '0;
      r_data_hold <= '0;
    end else begin
      r_req       <= w_lookup_en;
      r_data_hold <= instruction_data;
      if (w_lookup_en) begin
        r_tag   <= w_req_tag;
        r_index <= w_req_index;
      end
    end
  end

  // Data and tag RAMs: synchronous read for lookups, write during fill.
  always_ff @(posedge CLK) begin
    if (w_lookup_en) begin
      r_ram_q <= r_data_ram[{w_req_index, w_req_offset}];
      r_tag_q <= r_tag_ram[w_req_index];
    end
    if (w_beat_we) begin
      r_data_ram[{r_fill_index, r_beat}] <= mem_data;
    end
    if (w_tag_we) begin
      r_tag_ram[r_fill_index] <= r_fill_tag;
    end
  end

  // Fill controller, valid bits and flush handling.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state         <= ST_IDLE;
      r_mem_request   <= 1'b0;
      r_cache_busy    <= 1'b0;
      r_mem_address   <= '0;
      r_fill_tag      <= '0;
      r_fill_index    <= '0;
      r_beat          <= '0;
      r_flush_pending <= 1'b0;
      r_valid         <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cache_flush) begin
            r_valid <= '0;
          end else if (w_miss) begin
            r_state       <= ST_FILL_REQ;
            r_mem_request <= 1'b1;
            r_cache_busy  <= 1'b1;
            r_fill_tag    <= r_tag;
            r_fill_index  <= r_index;
            r_mem_address <= {r_tag, r_index, {(OFFSET_BITS + 2){1'b0}}};
          end
        end
        ST_FILL_REQ: begin
          if (cache_flush) begin
            r_flush_pending <= 1'b1;
          end
          if (mem_grant) begin
            r_state       <= ST_FILL_DATA;
            r_mem_request <= 1'b0;
            r_beat        <= '0;
          end
        end
        ST_FILL_DATA: begin
          if (cache_flush) begin
            r_flush_pending <= 1'b1;
          end
          if (mem_data_valid) begin
            r_beat <= r_beat + OFFSET_BITS'(1);
            if (r_beat == LAST_BEAT) begin
              r_valid[r_fill_index] <= 1'b1;
              r_state               <= ST_FILL_DONE;
            end
          end
        end
        ST_FILL_DONE: begin
          // A flush seen at any point during the fill also discards the line just written.
          if (r_flush_pending || cache_flush) begin
            r_valid <= '0;
          end
          r_flush_pending <= 1'b0;
          r_cache_busy    <= 1'b0;
          r_state         <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slurm32_cpu_instruction_cache.sv
// Scoreboard bench for the SLURM32 instruction cache: directed fetch/fill sequences,
// expected hit data and fill addresses are queued and checked by an independent monitor.
module tb_slurm32_cpu_instruction_cache;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        instruction_request = 1'b0;
  logic [31:0] instruction_address = 32'd0;
  logic [31:0] instruction_data;
  logic        instruction_valid;
  logic        cache_flush = 1'b0;
  logic        cache_busy;
  logic        mem_request;
  logic [31:0] mem_address;
  logic        mem_grant = 1'b0;
  logic [31:0] mem_data = 32'd0;
  logic        mem_data_valid = 1'b0;

  int n_vec  = 0;
  int n_fail = 0;

  logic [31:0] hit_q  [$];
  logic [31:0] addr_q [$];

  slurm32_cpu_instruction_cache dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .instruction_request (instruction_request),
    .instruction_address (instruction_address),
    .instruction_data    (instruction_data),
    .instruction_valid   (instruction_valid),
    .cache_flush         (cache_flush),
    .cache_busy          (cache_busy),
    .mem_request         (mem_request),
    .mem_address         (mem_address),
    .mem_grant           (mem_grant),
    .mem_data            (mem_data),
    .mem_data_valid      (mem_data_valid)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every presented hit and every new fill request is matched against the queues.
  logic prev_mreq = 1'b0;
  always @(negedge CLK) begin : monitor
    logic [31:0] exp_v;
    if (!RST) begin
      if (instruction_valid) begin
        if (hit_q.size() == 0) begin
          chk("unexpected_valid", 32'(instruction_valid), 32'd0);
        end else begin
          exp_v = hit_q.pop_front();
          chk("hit_data", instruction_data, exp_v);
        end
      end
      if (mem_request && !prev_mreq) begin
        if (addr_q.size() == 0) begin
          chk("unexpected_mem_request", 32'(mem_request), 32'd0);
        end else begin
          exp_v = addr_q.pop_front();
          chk("mem_address", mem_address, exp_v);
        end
      end
    end
    prev_mreq = mem_request;
  end

  task automatic fetch(input logic [31:0] addr, input bit hit, input logic [31:0] data);
    instruction_request = 1'b1;
    instruction_address = addr;
    if (hit) hit_q.push_back(data);
    tick();
    instruction_request = 1'b0;
    if (!hit) chk("miss_valid", 32'(instruction_valid), 32'd0);
  endtask

  task automatic drain();
    tick();
    chk("hit_queue_drained", 32'(hit_q.size()), 32'd0);
    chk("addr_queue_drained", 32'(addr_q.size()), 32'd0);
  endtask

  // Arbiter model: wait for the request, grant, then stream beats d0+0..d0+3.
  task automatic do_fill(input logic [31:0] d0, input int flush_at, input int abort_at);
    int  n;
    bit  aborted;
    n = 0;
    aborted = 1'b0;
    while (!mem_request && n < 20) begin
      tick();
      n++;
    end
    chk("fill_request_seen", 32'(mem_request), 32'd1);
    chk("busy_in_fill_req", 32'(cache_busy), 32'd1);
    mem_grant = 1'b1;
    tick();
    mem_grant = 1'b0;
    chk("mem_request_dropped", 32'(mem_request), 32'd0);
    for (int b = 0; b < 4; b++) begin
      if (!aborted) begin
        if (b == abort_at) begin
          RST = 1'b1;
          #1;
          chk("reset_mem_request", 32'(mem_request), 32'd0);
          chk("reset_valid", 32'(instruction_valid), 32'd0);
          chk("reset_busy", 32'(cache_busy), 32'd0);
          tick();
          RST = 1'b0;
          tick();
          aborted = 1'b1;
        end else begin
          mem_data_valid = 1'b1;
          mem_data       = d0 + 32'(b);
          cache_flush    = (b == flush_at);
          tick();
          cache_flush    = 1'b0;
          if (flush_at >= 0) chk("busy_flush_pending", 32'(cache_busy), 32'd1);
        end
      end
    end
    mem_data_valid = 1'b0;
    if (!aborted) begin
      chk("busy_in_fill_done", 32'(cache_busy), 32'd1);
      tick();
      chk("busy_after_fill", 32'(cache_busy), 32'd0);
    end
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_valid", 32'(instruction_valid), 32'd0);
    chk("rst_data", instruction_data, 32'd0);
    chk("rst_mem_request", 32'(mem_request), 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_busy", 32'(cache_busy), 32'd0);
    RST = 1'b0;
    tick();

    // Cold miss then hit on word 1.
    addr_q.push_back(32'h0000_0100);
    fetch(32'h0000_0100, 1'b0, 32'd0);
    do_fill(32'h0000_00A0, -1, -1);
    fetch(32'h0000_0104, 1'b1, 32'h0000_00A1);
    drain();

    // Streaming hits over the whole line.
    fetch(32'h0000_0100, 1'b1, 32'h0000_00A0);
    fetch(32'h0000_0104, 1'b1, 32'h0000_00A1);
    fetch(32'h0000_0108, 1'b1, 32'h0000_00A2);
    fetch(32'h0000_010C, 1'b1, 32'h0000_00A3);
    drain();

    // Conflict eviction on the shared index; data holds across the miss.
    addr_q.push_back(32'h0000_0500);
    fetch(32'h0000_0500, 1'b0, 32'd0);
    do_fill(32'h0000_00B0, -1, -1);
    fetch(32'h0000_0500, 1'b1, 32'h0000_00B0);
    addr_q.push_back(32'h0000_0100);
    fetch(32'h0000_0100, 1'b0, 32'd0);
    chk("data_hold_on_miss", instruction_data, 32'h0000_00B0);
    do_fill(32'h0000_00A0, -1, -1);
    fetch(32'h0000_010C, 1'b1, 32'h0000_00A3);
    drain();

    // Flush in idle.
    cache_flush = 1'b1;
    tick();
    cache_flush = 1'b0;
    addr_q.push_back(32'h0000_0100);
    fetch(32'h0000_0100, 1'b0, 32'd0);
    do_fill(32'h0000_00A0, -1, -1);
    fetch(32'h0000_0100, 1'b1, 32'h0000_00A0);
    drain();

    // Flush during a fill discards everything once the fill ends.
    addr_q.push_back(32'h0000_0500);
    fetch(32'h0000_0500, 1'b0, 32'd0);
    do_fill(32'h0000_00B0, 2, -1);
    addr_q.push_back(32'h0000_0100);
    fetch(32'h0000_0100, 1'b0, 32'd0);
    do_fill(32'h0000_00A0, -1, -1);
    fetch(32'h0000_0108, 1'b1, 32'h0000_00A2);
    drain();

    // Reset during a fill after two beats.
    addr_q.push_back(32'h0000_0500);
    fetch(32'h0000_0500, 1'b0, 32'd0);
    do_fill(32'h0000_00B0, -1, 2);
    addr_q.push_back(32'h0000_0100);
    fetch(32'h0000_0100, 1'b0, 32'd0);
    do_fill(32'h0000_00C0, -1, -1);
    fetch(32'h0000_0104, 1'b1, 32'h0000_00C1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
